host_xfer_seq: RTL and testbench

- Parametrised host-facing transfer sequencer for the ECC datapath.
- Loads NUM_IN operand words of DATA_W bits from a narrow BUS_W host bus, beat by beat, then releases the compute engines.
- Exports NUM_OUT result slots back to the host beat by beat, each slot gated by its own engine-valid signal.
- Every host step carries a sequence code that must match the expected code; mismatches and stalled engines are flagged as errors.

---
 rtl/host_xfer_pkg.sv | 25 ++
 rtl/host_xfer_seq_beat_assembler.sv | 62 ++++++
 rtl/host_xfer_seq.sv | 180 ++++++++++++++++++
 tb/tb_host_xfer_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/host_xfer_pkg.sv
// Shared types and sizing helpers for the host transfer sequencer.
// The FSM state encoding, error-bit positions and beat/pointer sizing live here.
package host_xfer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      EXPORT,
      FINISH,
      ERROR
   } state_t;

   localparam int ERR_CODE    = 0;
   localparam int ERR_TIMEOUT = 1;

   function automatic int calc_beats(input int data_w, input int bus_w);
      return data_w / bus_w;
   endfunction

   // A pointer over n entries needs at least one bit, even when n is 1.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/host_xfer_seq_beat_assembler.sv
// Serial-to-parallel operand loader: each write enable stores one bus beat.
// Beats fill a word LSB first, and words fill in index order.
module beat_assembler
   import host_xfer_pkg::*;
#(
   parameter int DATA_W = 256,
   parameter int BUS_W  = 32,
   parameter int NUM_IN = 2
) (
   input  logic                     Clk,
   input  logic                     reset,
   input  logic                     i_clear,
   input  logic                     i_wr_en,
   input  logic [BUS_W-1:0]         i_wdata,
   output logic [NUM_IN*DATA_W-1:0] o_words,
   output logic                     o_last
);

   localparam int BEATS  = calc_beats(DATA_W, BUS_W);
   localparam int BEAT_W = ptr_w(BEATS);
   localparam int WORD_W = ptr_w(NUM_IN);

   logic [BEAT_W-1:0] r_beat;
   logic [WORD_W-1:0] r_word;
   logic              w_last_beat;
   logic              w_last_word;

   assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
   assign w_last_word = (r_word == WORD_W'(NUM_IN - 1));
   assign o_last      = w_last_beat && w_last_word;

   always_ff @(posedge Clk) begin
      if (reset || i_clear) begin
         r_beat <= '0;
         r_word <= '0;
      end else if (i_wr_en) begin
         if (w_last_beat) begin
            r_beat <= '0;
            r_word <= w_last_word ? '0 : r_word + 1'b1;
         end else begin
            r_beat <= r_beat + 1'b1;
         end
      end
   end

   // Operand storage survives i_clear so a restarted host can still read it.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_IN; gi++) begin : g_word
         logic [DATA_W-1:0] r_data;
         always_ff @(posedge Clk) begin
            if (reset) begin
               r_data <= '0;
            end else if (i_wr_en && !i_clear && (r_word == WORD_W'(gi))) begin
               r_data[r_beat*BUS_W +: BUS_W] <= i_wdata;
            end
         end
         assign o_words[gi*DATA_W +: DATA_W] = r_data;
      end
   endgenerate

endmodule

// File: rtl/host_xfer_seq.sv
// Host transfer sequencer: code-checked operand load, engine release and
// slot-by-slot result export, with sticky mismatch/timeout error flags.
module host_xfer_seq
   import host_xfer_pkg::*;
#(
   parameter int DATA_W  = 256,
   parameter int BUS_W   = 32,
   parameter int NUM_IN  = 2,
   parameter int NUM_OUT = 10,
   parameter int STEP_W  = 8,
   parameter int TIMEOUT = 1048576
) (
   input  logic                      Clk,
   input  logic                      reset,
   input  logic                      host_strobe,
   input  logic [STEP_W-1:0]         host_code,
   input  logic [BUS_W-1:0]          host_wdata,
   input  logic                      host_restart,
   output logic [NUM_IN*DATA_W-1:0]  in_words,
   output logic                      in_valid,
   output logic                      engine_run,
   input  logic [NUM_OUT*DATA_W-1:0] res_data,
   input  logic [NUM_OUT-1:0]        res_valid,
   output logic [BUS_W-1:0]          host_rdata,
   output logic                      rdata_valid,
   output logic                      busy,
   output logic                      done,
   output logic [1:0]                err
);

   localparam int BEATS  = calc_beats(DATA_W, BUS_W);
   localparam int BEAT_W = ptr_w(BEATS);
   localparam int SLOT_W = ptr_w(NUM_OUT);
   localparam int WAIT_W = ptr_w(TIMEOUT);

   state_t            r_state, w_state_next;
   logic [STEP_W-1:0] r_cnt, w_cnt_next;
   logic [SLOT_W-1:0] r_slot, w_slot_next;
   logic [BEAT_W-1:0] r_beat, w_beat_next;
   logic [WAIT_W-1:0] r_wait, w_wait_next;
   logic [1:0]        r_err, w_err_next;
   logic              w_code_ok;
   logic              w_slot_valid;
   logic              w_load_wr;
   logic              w_load_last;
   logic              w_timeout_hit;
   logic [BUS_W-1:0]  w_beats [NUM_OUT][BEATS];

   genvar gi, gj;
   generate
      for (gi = 0; gi < NUM_OUT; gi++) begin : g_slot
         for (gj = 0; gj < BEATS; gj++) begin : g_beat
            assign w_beats[gi][gj] = res_data[gi*DATA_W + gj*BUS_W +: BUS_W];
         end
      end
      if (TIMEOUT != 0) begin : g_timeout
         assign w_timeout_hit = (r_wait == WAIT_W'(TIMEOUT - 1));
      end else begin : g_no_timeout
         assign w_timeout_hit = 1'b0;
      end
   endgenerate

   assign w_code_ok    = (host_code == r_cnt);
   assign w_slot_valid = res_valid[r_slot];

   beat_assembler #(
      .DATA_W (DATA_W),
      .BUS_W  (BUS_W),
      .NUM_IN (NUM_IN)
   ) u_asm (
      .Clk     (Clk),
      .reset   (reset),
      .i_clear (host_restart),
      .i_wr_en (w_load_wr),
      .i_wdata (host_wdata),
      .o_words (in_words),
      .o_last  (w_load_last)
   );

   always_ff @(posedge Clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_slot  <= '0;
         r_beat  <= '0;
         r_wait  <= '0;
         r_err   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_slot  <= w_slot_next;
         r_beat  <= w_beat_next;
         r_wait  <= w_wait_next;
         r_err   <= w_err_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_slot_next  = r_slot;
      w_beat_next  = r_beat;
      w_wait_next  = r_wait;
      w_err_next   = r_err;
      w_load_wr    = 1'b0;
      case (r_state)
         IDLE: begin
            if (host_strobe && (host_code == '0)) begin
               w_cnt_next   = r_cnt + 1'b1;
               w_state_next = LOAD;
            end
         end
         LOAD: begin
            if (host_strobe) begin
               if (w_code_ok) begin
                  w_load_wr  = 1'b1;
                  w_cnt_next = r_cnt + 1'b1;
                  if (w_load_last) w_state_next = EXPORT;
               end else begin
                  w_err_next[ERR_CODE] = 1'b1;
                  w_state_next         = ERROR;
               end
            end
         end
         EXPORT: begin
            // The wait counter only runs while the current slot is not ready.
            if (!w_slot_valid) begin
               if (w_timeout_hit) begin
                  w_err_next[ERR_TIMEOUT] = 1'b1;
                  w_state_next            = ERROR;
               end else begin
                  w_wait_next = r_wait + 1'b1;
               end
            end else begin
               w_wait_next = '0;
            end
            if (host_strobe) begin
               if (!w_code_ok) begin
                  w_err_next[ERR_CODE] = 1'b1;
                  w_state_next         = ERROR;
               end else if (w_slot_valid) begin
                  w_cnt_next = r_cnt + 1'b1;
                  if (r_beat == BEAT_W'(BEATS - 1)) begin
                     w_beat_next = '0;
                     w_wait_next = '0;
                     if (r_slot == SLOT_W'(NUM_OUT - 1)) begin
                        w_slot_next  = '0;
                        w_state_next = FINISH;
                     end else begin
                        w_slot_next = r_slot + 1'b1;
                     end
                  end else begin
                     w_beat_next = r_beat + 1'b1;
                  end
               end
            end
         end
         default: ;
      endcase
      // Restart overrides everything decided above, including a same-cycle strobe.
      if (host_restart) begin
         w_state_next = IDLE;
         w_cnt_next   = '0;
         w_slot_next  = '0;
         w_beat_next  = '0;
         w_wait_next  = '0;
         w_err_next   = '0;
         w_load_wr    = 1'b0;
      end
   end

   assign in_valid    = (r_state == EXPORT) || (r_state == FINISH);
   assign engine_run  = in_valid;
   assign busy        = (r_state == LOAD) || (r_state == EXPORT);
   assign done        = (r_state == FINISH);
   assign err         = r_err;
   assign rdata_valid = (r_state == EXPORT) && w_slot_valid;
   assign host_rdata  = (r_state == EXPORT) ? w_beats[r_slot][r_beat] : '0;

endmodule

// File: tb/tb_host_xfer_seq.sv
// Directed bench: dut_a runs default parameters, dut_b runs STEP_W=4 and
// TIMEOUT=16 for the code-wrap and timeout cases.
module tb_host_xfer_seq;

   localparam int DATA_W  = 256;
   localparam int BUS_W   = 32;
   localparam int NUM_IN  = 2;
   localparam int NUM_OUT = 10;

   logic Clk = 1'b0;
   logic reset = 1'b1;
   always #5 Clk = ~Clk;

   logic [NUM_OUT*DATA_W-1:0] res_data;

   logic                      stb_a = 1'b0, rst_a = 1'b0;
   logic [7:0]                code_a = '0;
   logic [BUS_W-1:0]          wdata_a = '0;
   logic [NUM_OUT-1:0]        rv_a = '0;
   logic [NUM_IN*DATA_W-1:0]  words_a;
   logic                      inv_a, run_a, rdv_a, busy_a, done_a;
   logic [BUS_W-1:0]          rdata_a;
   logic [1:0]                err_a;

   logic                      stb_b = 1'b0, rst_b = 1'b0;
   logic [3:0]                code_b = '0;
   logic [BUS_W-1:0]          wdata_b = '0;
   logic [NUM_OUT-1:0]        rv_b = '0;
   logic [NUM_IN*DATA_W-1:0]  words_b;
   logic                      inv_b, run_b, rdv_b, busy_b, done_b;
   logic [BUS_W-1:0]          rdata_b;
   logic [1:0]                err_b;

   int n_cmp = 0;
   int n_bad = 0;

   host_xfer_seq dut_a (
      .Clk(Clk), .reset(reset), .host_strobe(stb_a), .host_code(code_a),
      .host_wdata(wdata_a), .host_restart(rst_a), .in_words(words_a),
      .in_valid(inv_a), .engine_run(run_a), .res_data(res_data),
      .res_valid(rv_a), .host_rdata(rdata_a), .rdata_valid(rdv_a),
      .busy(busy_a), .done(done_a), .err(err_a)
   );

   host_xfer_seq #(.STEP_W(4), .TIMEOUT(16)) dut_b (
      .Clk(Clk), .reset(reset), .host_strobe(stb_b), .host_code(code_b),
      .host_wdata(wdata_b), .host_restart(rst_b), .in_words(words_b),
      .in_valid(inv_b), .engine_run(run_b), .res_data(res_data),
      .res_valid(rv_b), .host_rdata(rdata_b), .rdata_valid(rdv_b),
      .busy(busy_b), .done(done_b), .err(err_b)
   );

   function automatic logic [31:0] pat(input int k, input int b);
      return 32'hC0DE_0000 | (32'(k) << 8) | 32'(b);
   endfunction

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic strobe_a(input logic [7:0] code, input logic [31:0] wd);
      code_a = code; wdata_a = wd; stb_a = 1'b1;
      tick();
      stb_a = 1'b0;
   endtask

   task automatic strobe_b(input logic [3:0] code);
      code_b = code; wdata_b = 32'(code); stb_b = 1'b1;
      tick();
      stb_b = 1'b0;
   endtask

   task automatic restart_a();
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < NUM_OUT; k++)
         for (int b = 0; b < 8; b++)
            res_data[k*DATA_W + b*BUS_W +: BUS_W] = pat(k, b);

      // Power-on reset
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      check_eq("rst_busy", busy_a, 1'b0);
      check_eq("rst_done", done_a, 1'b0);
      check_eq("rst_inv", inv_a, 1'b0);
      check_eq("rst_run", run_a, 1'b0);
      check_eq("rst_err", err_a, 2'b00);
      check_eq("rst_rdata", rdata_a, 32'h0);
      check_eq("rst_words", words_a[255:0], 256'h0);
      $display("reset checked");

      // 1. Full run
      rv_a = '1;
      strobe_a(8'd5, 32'h0);
      check_eq("idle_ignore", busy_a, 1'b0);
      strobe_a(8'd0, 32'h0);
      check_eq("t1_busy", busy_a, 1'b1);
      for (int c = 1; c <= 16; c++) begin
         strobe_a(8'(c), 32'(c - 1));
         $display("load code %0d wdata %0h busy %0b in_valid %0b", c, c - 1, busy_a, inv_a);
         if (c == 15) check_eq("t1_inv_early", inv_a, 1'b0);
      end
      check_eq("t1_inv", inv_a, 1'b1);
      check_eq("t1_run", run_a, 1'b1);
      check_eq("t1_word0", words_a[255:0],
               256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);
      check_eq("t1_word1", words_a[511:256],
               256'h0000000F_0000000E_0000000D_0000000C_0000000B_0000000A_00000009_00000008);
      for (int c = 17; c <= 96; c++) begin
         check_eq("t1_rdata", rdata_a, pat((c - 17) / 8, (c - 17) % 8));
         $display("export code %0d rdata %0h", c, rdata_a);
         strobe_a(8'(c), 32'h0);
      end
      check_eq("t1_done", done_a, 1'b1);
      check_eq("t1_busy_end", busy_a, 1'b0);
      check_eq("t1_err", err_a, 2'b00);
      check_eq("t1_run_end", run_a, 1'b1);
      strobe_a(8'd97, 32'h0);
      check_eq("t1_finish_hold", done_a, 1'b1);

      // 2. Gated slot
      restart_a();
      check_eq("t2_restart_done", done_a, 1'b0);
      rv_a = 10'h3F7;
      strobe_a(8'd0, 32'h0);
      for (int c = 1; c <= 40; c++) strobe_a(8'(c), 32'(c - 1));
      check_eq("t2_rdv_low", rdv_a, 1'b0);
      strobe_a(8'd41, 32'h0);
      $display("gated strobe 41 err %0b rdata %0h", err_a, rdata_a);
      check_eq("t2_err", err_a, 2'b00);
      check_eq("t2_busy", busy_a, 1'b1);
      check_eq("t2_hold", rdata_a, pat(3, 0));
      rv_a[3] = 1'b1;
      #1;
      check_eq("t2_rdv_high", rdv_a, 1'b1);
      strobe_a(8'd41, 32'h0);
      check_eq("t2_adv", rdata_a, pat(3, 1));
      strobe_a(8'd42, 32'h0);
      check_eq("t2_adv2", rdata_a, pat(3, 2));
      check_eq("t2_err2", err_a, 2'b00);

      // 3. Mismatch
      restart_a();
      check_eq("t3_idle", busy_a, 1'b0);
      strobe_a(8'd0, 32'h0);
      strobe_a(8'd1, 32'hDEAD_0001);
      strobe_a(8'd2, 32'hDEAD_0002);
      strobe_a(8'd5, 32'hDEAD_0005);
      $display("mismatch strobe 5 err %0b busy %0b", err_a, busy_a);
      check_eq("t3_err", err_a, 2'b01);
      check_eq("t3_busy", busy_a, 1'b0);
      check_eq("t3_run", run_a, 1'b0);
      strobe_a(8'd3, 32'h0);
      check_eq("t3_sticky", err_a, 2'b01);
      check_eq("t3_ignored", busy_a, 1'b0);
      restart_a();
      check_eq("t3_clear", err_a, 2'b00);

      // 5. Restart collision
      strobe_a(8'd0, 32'h0);
      check_eq("t5_start", busy_a, 1'b1);
      rv_a = '1;
      for (int c = 1; c <= 16; c++) strobe_a(8'(c), 32'hA000_0000 + 32'(c));
      for (int c = 17; c <= 30; c++) strobe_a(8'(c), 32'h0);
      code_a = 8'd31; stb_a = 1'b1; rst_a = 1'b1;
      tick();
      stb_a = 1'b0; rst_a = 1'b0;
      $display("collision busy %0b done %0b in_valid %0b", busy_a, done_a, inv_a);
      check_eq("t5_busy", busy_a, 1'b0);
      check_eq("t5_done", done_a, 1'b0);
      check_eq("t5_inv", inv_a, 1'b0);
      check_eq("t5_run", run_a, 1'b0);
      check_eq("t5_word0", words_a[255:0],
               256'hA0000008_A0000007_A0000006_A0000005_A0000004_A0000003_A0000002_A0000001);
      check_eq("t5_word1", words_a[511:256],
               256'hA0000010_A000000F_A000000E_A000000D_A000000C_A000000B_A000000A_A0000009);
      strobe_a(8'd31, 32'h0);
      check_eq("t5_need0", busy_a, 1'b0);
      strobe_a(8'd0, 32'h0);
      check_eq("t5_code0", busy_a, 1'b1);

      // 6. Code wrap on dut_b (STEP_W=4)
      rv_b = '1;
      for (int c = 0; c <= 96; c++) begin
         if (c == 20) check_eq("t6_rdata", rdata_b, pat(0, 3));
         strobe_b(4'(c));
         if (c == 16) begin
            check_eq("t6_wrap_inv", inv_b, 1'b1);
            check_eq("t6_wrap_err", err_b, 2'b00);
         end
      end
      $display("wrap run done %0b err %0b", done_b, err_b);
      check_eq("t6_done", done_b, 1'b1);
      check_eq("t6_err", err_b, 2'b00);

      // 4. Timeout on dut_b (TIMEOUT=16)
      rst_b = 1'b1;
      tick();
      rst_b = 1'b0;
      rv_b = '0;
      for (int c = 0; c <= 16; c++) strobe_b(4'(c));
      check_eq("t4_export", busy_b, 1'b1);
      repeat (15) tick();
      check_eq("t4_err_early", err_b, 2'b00);
      tick();
      $display("timeout err %0b run %0b", err_b, run_b);
      check_eq("t4_err", err_b, 2'b10);
      check_eq("t4_run", run_b, 1'b0);
      check_eq("t4_busy", busy_b, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
